// File: rtl/ad_capture_module.sv
// ADC capture engine: divides the system clock down to the ADC sample rate, waits for a
// level-crossing (or timeout) trigger, then records DEPTH samples into a readable buffer.
module ad_capture_module #(
    parameter int DIV     = 97,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 2048
) (
    input  logic              CLK_50M,
    input  logic              RST_N,
    input  logic [7:0]        ad_data,
    input  logic [7:0]        trig_level,
    input  logic              trig_edge,
    input  logic              arm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              ad_clk,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              capture_done,
    output logic              auto_trig
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TRIG,
        CAPTURE,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [DIV_W-1:0]  div_cnt;
    logic              sample_en, sample_d;
    logic [7:0]        cur, prev;
    logic              cur_valid, prev_valid;
    logic [TO_W-1:0]   tcnt, tcnt_d;
    logic [ADDR_W-1:0] wptr, wptr_d, wr_addr;
    logic              auto_flag, auto_flag_d;
    logic              wr_en, clr_valid;
    logic              trig_rise, trig_fall, trig_hit;
    logic [7:0]        mem [DEPTH];

    assign sample_en = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt  <= '0;
            ad_clk   <= 1'b0;
            sample_d <= 1'b0;
        end else begin
            div_cnt  <= sample_en ? '0 : div_cnt + 1'b1;
            ad_clk   <= (div_cnt < DIV_W'(DIV / 2));
            sample_d <= sample_en;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            cur        <= '0;
            prev       <= '0;
            cur_valid  <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            if (sample_en) begin
                cur        <= ad_data;
                prev       <= cur;
                prev_valid <= cur_valid;
                cur_valid  <= 1'b1;
            end
            // NOTE: the later non-blocking assignment wins, so re-arming on a sample
            // edge still invalidates the history even though cur takes the new sample.
            if (clr_valid) begin
                cur_valid  <= 1'b0;
                prev_valid <= 1'b0;
            end
        end
    end

    assign trig_rise = (prev < trig_level) && (cur >= trig_level);
    assign trig_fall = (prev > trig_level) && (cur <= trig_level);
    assign trig_hit  = prev_valid && (trig_edge ? trig_fall : trig_rise);

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            wptr      <= '0;
            tcnt      <= '0;
            auto_flag <= 1'b0;
        end else begin
            state     <= state_d;
            wptr      <= wptr_d;
            tcnt      <= tcnt_d;
            auto_flag <= auto_flag_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state;
        wptr_d      = wptr;
        tcnt_d      = tcnt;
        auto_flag_d = auto_flag;
        wr_en       = 1'b0;
        wr_addr     = wptr;
        clr_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_d   = WAIT_TRIG;
                    clr_valid = 1'b1;
                    tcnt_d    = '0;
                end
            end
            WAIT_TRIG: begin
                if (sample_d) begin
                    if (trig_hit || tcnt == TO_W'(TIMEOUT - 1)) begin
                        state_d     = CAPTURE;
                        auto_flag_d = !trig_hit;
                        wr_en       = 1'b1;
                        wr_addr     = '0;
                        wptr_d      = ADDR_W'(1);
                    end else begin
                        tcnt_d = tcnt + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (sample_d) begin
                    wr_en = 1'b1;
                    if (wptr == ADDR_W'(DEPTH - 1)) begin
                        state_d = DONE;
                        wptr_d  = '0;
                    end else begin
                        wptr_d = wptr + 1'b1;
                    end
                end
            end
            DONE: begin
                if (arm) begin
                    state_d     = WAIT_TRIG;
                    clr_valid   = 1'b1;
                    tcnt_d      = '0;
                    auto_flag_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the buffer has no reset so it maps onto block RAM; only the read register clears.
    always_ff @(posedge CLK_50M) begin
        if (wr_en) mem[wr_addr] <= cur;
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

    assign busy         = (state == WAIT_TRIG) || (state == CAPTURE);
    assign capture_done = (state == DONE);
    assign auto_trig    = capture_done && auto_flag;

endmodule
